// File: rtl/sync_fifo_stream.sv
// Single-clock stream FIFO with occupancy level, almost-full/empty thresholds, flush and write-through-when-full.
// Define SYNC_FIFO_STREAM_ERR_EN to add sticky ovf/udf error flags with an err_clr input.
module sync_fifo_stream #(
    parameter int DATA_W     = 24,
    parameter int ADDR_BITS  = 10,
    parameter int AFULL_LVL  = (1 << ADDR_BITS) - 4,
    parameter int AEMPTY_LVL = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                w_en,
    input  logic [DATA_W-1:0]   w_data,
    output logic                w_full,
    output logic                almost_full,
    input  logic                r_en,
    output logic [DATA_W-1:0]   r_data,
    output logic                r_valid,
    output logic                r_empty,
    output logic                almost_empty,
    output logic [ADDR_BITS:0]  level
`ifdef SYNC_FIFO_STREAM_ERR_EN
    ,
    output logic                ovf,
    output logic                udf,
    input  logic                err_clr
`endif
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0]   DEPTH_C  = (ADDR_BITS+1)'(DEPTH);
    localparam logic [ADDR_BITS:0]   AFULL_C  = (ADDR_BITS+1)'(AFULL_LVL);
    localparam logic [ADDR_BITS:0]   AEMPTY_C = (ADDR_BITS+1)'(AEMPTY_LVL);
    localparam logic [ADDR_BITS:0]   LVL_ONE  = (ADDR_BITS+1)'(1);
    localparam logic [ADDR_BITS-1:0] PTR_ONE  = ADDR_BITS'(1);

    if (ADDR_BITS < 1) begin : g_bad_addr
        $fatal(1, "sync_fifo_stream: ADDR_BITS must be >= 1");
    end
    if (AFULL_LVL > DEPTH || AFULL_LVL < 1) begin : g_bad_afull
        $fatal(1, "sync_fifo_stream: AFULL_LVL must be in 1..DEPTH");
    end
    if (AEMPTY_LVL >= AFULL_LVL || AEMPTY_LVL < 0) begin : g_bad_aempty
        $fatal(1, "sync_fifo_stream: AEMPTY_LVL must be in 0..AFULL_LVL-1");
    end

    logic [DATA_W-1:0]    mem_r [DEPTH];
    logic [ADDR_BITS-1:0] wptr_r;
    logic [ADDR_BITS-1:0] rptr_r;
    logic [ADDR_BITS:0]   level_r;
    logic [ADDR_BITS:0]   level_nxt_s;
    logic [DATA_W-1:0]    r_data_r;
    logic                 r_valid_r;
    logic                 r_empty_r;
    logic                 w_full_r;
    logic                 almost_full_r;
    logic                 almost_empty_r;
    logic                 r_acc_s;
    logic                 w_acc_s;

    // A full FIFO still takes a write when the same cycle frees a slot by reading.
    assign r_acc_s = r_en & ~r_empty_r;
    assign w_acc_s = w_en & (~w_full_r | r_acc_s);

    // Next occupancy from the accepted read/write pair.
    always_comb begin
        level_nxt_s = level_r;
        case ({w_acc_s, r_acc_s})
            2'b10:   level_nxt_s = level_r + LVL_ONE;
            2'b01:   level_nxt_s = level_r - LVL_ONE;
            default: level_nxt_s = level_r;
        endcase
    end

    // Storage array; flush and reset suppress the write but never clear contents.
    always_ff @(posedge clk) begin
        if (!rst && !flush && w_acc_s) begin
            mem_r[wptr_r] <= w_data;
        end
    end

    // Pointers, level, registered read data and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_r         <= '0;
            rptr_r         <= '0;
            level_r        <= '0;
            r_data_r       <= '0;
            r_valid_r      <= 1'b0;
            r_empty_r      <= 1'b1;
            w_full_r       <= 1'b0;
            almost_full_r  <= 1'b0;
            almost_empty_r <= 1'b1;
        end else if (flush) begin
            wptr_r         <= '0;
            rptr_r         <= '0;
            level_r        <= '0;
            r_valid_r      <= 1'b0;
            r_empty_r      <= 1'b1;
            w_full_r       <= 1'b0;
            almost_full_r  <= 1'b0;
            almost_empty_r <= 1'b1;
        end else begin
            if (w_acc_s) begin
                wptr_r <= wptr_r + PTR_ONE;
            end
            if (r_acc_s) begin
                rptr_r   <= rptr_r + PTR_ONE;
                r_data_r <= mem_r[rptr_r];
            end
            r_valid_r      <= r_acc_s;
            level_r        <= level_nxt_s;
            r_empty_r      <= (level_nxt_s == '0);
            w_full_r       <= (level_nxt_s == DEPTH_C);
            almost_full_r  <= (level_nxt_s >= AFULL_C);
            almost_empty_r <= (level_nxt_s <= AEMPTY_C);
        end
    end

    assign level        = level_r;
    assign r_data       = r_data_r;
    assign r_valid      = r_valid_r;
    assign r_empty      = r_empty_r;
    assign w_full       = w_full_r;
    assign almost_full  = almost_full_r;
    assign almost_empty = almost_empty_r;

`ifdef SYNC_FIFO_STREAM_ERR_EN
    logic ovf_r;
    logic udf_r;
    logic ovf_set_s;
    logic udf_set_s;

    assign ovf_set_s = w_en & ~w_acc_s;
    assign udf_set_s = r_en & r_empty_r;

    // Sticky error flags: set beats clear, flush leaves them alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= 1'b0;
            udf_r <= 1'b0;
        end else begin
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end else if (err_clr) begin
                ovf_r <= 1'b0;
            end
            if (udf_set_s) begin
                udf_r <= 1'b1;
            end else if (err_clr) begin
                udf_r <= 1'b0;
            end
        end
    end

    assign ovf = ovf_r;
    assign udf = udf_r;
`endif

endmodule

// File: tb/tb_sync_fifo_stream.sv
// Scoreboard bench for sync_fifo_stream (DEPTH=16, AFULL=12, AEMPTY=2).
// Error-flag checks are included when SYNC_FIFO_STREAM_ERR_EN is defined.
module tb_sync_fifo_stream;

    localparam int DW = 24;
    localparam int AB = 4;
    localparam int DEPTH = 16;
    localparam int AFULL = 12;
    localparam int AEMPTY = 2;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          w_en;
    logic [DW-1:0] w_data;
    logic          w_full;
    logic          almost_full;
    logic          r_en;
    logic [DW-1:0] r_data;
    logic          r_valid;
    logic          r_empty;
    logic          almost_empty;
    logic [AB:0]   level;
`ifdef SYNC_FIFO_STREAM_ERR_EN
    logic          ovf;
    logic          udf;
    logic          err_clr;
`endif

    sync_fifo_stream #(
        .DATA_W     (DW),
        .ADDR_BITS  (AB),
        .AFULL_LVL  (AFULL),
        .AEMPTY_LVL (AEMPTY)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .w_en         (w_en),
        .w_data       (w_data),
        .w_full       (w_full),
        .almost_full  (almost_full),
        .r_en         (r_en),
        .r_data       (r_data),
        .r_valid      (r_valid),
        .r_empty      (r_empty),
        .almost_empty (almost_empty),
        .level        (level)
`ifdef SYNC_FIFO_STREAM_ERR_EN
        ,
        .ovf          (ovf),
        .udf          (udf),
        .err_clr      (err_clr)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int            total_cnt = 0;
    int            bad_cnt = 0;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] last_rd;
    logic          last_wacc;
    logic          last_racc;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input logic exp_valid);
        int n;
        n = exp_q.size();
        check_val("r_valid", 32'(r_valid), 32'(exp_valid));
        check_val("r_data", 32'(r_data), 32'(last_rd));
        check_val("level", 32'(level), 32'(n));
        check_val("r_empty", 32'(r_empty), 32'(n == 0));
        check_val("w_full", 32'(w_full), 32'(n == DEPTH));
        check_val("almost_full", 32'(almost_full), 32'(n >= AFULL));
        check_val("almost_empty", 32'(almost_empty), 32'(n <= AEMPTY));
    endtask

    // One clock with the given inputs; scoreboard is updated from the bench's own acceptance rules.
    task automatic step(input logic we, input logic [DW-1:0] wd, input logic re, input logic fl);
        logic racc;
        logic wacc;
        racc = re && (exp_q.size() != 0) && !fl;
        wacc = we && ((exp_q.size() != DEPTH) || racc) && !fl;
        w_en = we; w_data = wd; r_en = re; flush = fl;
        @(posedge clk);
        #1;
        w_en = 1'b0; r_en = 1'b0; flush = 1'b0;
        if (fl) begin
            exp_q.delete();
        end else begin
            if (wacc) exp_q.push_back(wd);
            if (racc) last_rd = exp_q.pop_front();
        end
        last_wacc = wacc;
        last_racc = racc;
        check_outputs(racc);
    endtask

    task automatic do_reset(input logic we, input logic re);
        rst = 1'b1; w_en = we; w_data = 24'h5A5A5A; r_en = re; flush = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0; w_en = 1'b0; r_en = 1'b0;
        exp_q.delete();
        last_rd = '0;
        check_outputs(1'b0);
    endtask

    int pushed;

    initial begin
        rst = 1'b1; flush = 1'b0; w_en = 1'b0; r_en = 1'b0; w_data = '0;
`ifdef SYNC_FIFO_STREAM_ERR_EN
        err_clr = 1'b0;
`endif
        last_rd = '0;
        @(posedge clk);
        #1;
        do_reset(1'b0, 1'b0);

        // Fill with thresholds, then an overflowing write
        for (int i = 1; i <= 16; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
        check_val("full_lvl", 32'(level), 32'd16);
        step(1'b1, 24'hDEAD00, 1'b0, 1'b0);
        check_val("ovf_rejected", 32'(last_wacc), 32'd0);

        // Drain in order, then a read on empty
        for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1, 1'b0);
        check_val("drain_last", 32'(r_data), 32'h000010);
        step(1'b0, '0, 1'b1, 1'b0);
        check_val("empty_hold", 32'(r_data), 32'h000010);

        // Write through while full
        for (int i = 1; i <= 16; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
        step(1'b1, 24'hABCDEF, 1'b1, 1'b0);
        check_val("wt_data", 32'(r_data), 32'h000001);
        check_val("wt_level", 32'(level), 32'd16);
        for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1, 1'b0);
        check_val("wt_last", 32'(r_data), 32'hABCDEF);

        // Empty with simultaneous write: no bypass
        step(1'b1, 24'h123456, 1'b1, 1'b0);
        check_val("emp_wr_valid", 32'(r_valid), 32'd0);
        check_val("emp_wr_level", 32'(level), 32'd1);
        step(1'b0, '0, 1'b1, 1'b0);
        check_val("emp_wr_data", 32'(r_data), 32'h123456);

        // Random traffic across pointer wrap
        pushed = 0;
        for (int c = 0; c < 800 && (pushed < 40 || exp_q.size() != 0); c++) begin
            step((pushed < 40) && ($urandom_range(0, 1) == 1), DW'($urandom),
                 $urandom_range(0, 2) != 0, 1'b0);
            if (last_wacc) pushed++;
        end
        check_val("rnd_pushed", 32'(pushed), 32'd40);
        check_val("rnd_drained", 32'(exp_q.size()), 32'd0);

        // Flush at level 9 with w_en/r_en asserted
        for (int i = 0; i < 9; i++) step(1'b1, DW'(24'h300 + i), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, '0, 1'b0, 1'b0);
        check_val("pre_flush_lvl", 32'(level), 32'd9);
        step(1'b1, 24'h777777, 1'b1, 1'b1);
        check_val("flush_lvl", 32'(level), 32'd0);
        check_val("flush_rdata", 32'(r_data), 32'h000300);
        step(1'b1, 24'h0000AA, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        check_val("post_flush_rd", 32'(r_data), 32'h0000AA);

        // Reset at level 9 with w_en/r_en asserted
        for (int i = 0; i < 9; i++) step(1'b1, DW'(24'h400 + i), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, '0, 1'b0, 1'b0);
        do_reset(1'b1, 1'b1);
        check_val("rst_rdata", 32'(r_data), 32'd0);

`ifdef SYNC_FIFO_STREAM_ERR_EN
        // Sticky error flags
        step(1'b0, '0, 1'b1, 1'b0);
        check_val("udf_set", 32'(udf), 32'd1);
        check_val("ovf_clear", 32'(ovf), 32'd0);
        err_clr = 1'b1;
        step(1'b0, '0, 1'b0, 1'b0);
        err_clr = 1'b0;
        check_val("udf_clr", 32'(udf), 32'd0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        check_val("udf_flush", 32'(udf), 32'd1);
        for (int i = 0; i < 16; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
        step(1'b1, 24'hBAD000, 1'b0, 1'b0);
        check_val("ovf_set", 32'(ovf), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
